// File: rtl/lift_seq.sv
// 5/3 integer wavelet lifting-step sequencer driving the even/odd sample RAM pair.
// Define LIFT_SAT_EN to saturate write-back results instead of wrapping them.
module lift_seq #(
    parameter int W  = 26,
    parameter int AW = 7
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 fwd_inv,
    input  logic                 even_odd,
    input  logic [AW-1:0]        len_m1,
    output logic                 busy,
    output logic                 done,
    output logic [AW-1:0]        addr_even,
    output logic [AW-1:0]        addr_odd,
    output logic                 we_even,
    output logic                 we_odd,
    output logic signed [W-1:0]  din_even,
    output logic signed [W-1:0]  din_odd,
    input  logic signed [W-1:0]  dout_even,
    input  logic signed [W-1:0]  dout_odd
);

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        RD1,
        CALC,
        WR,
        FIN
    } state_t;

    localparam logic signed [W+1:0] TWO  = (W+2)'(2);
    localparam logic signed [W+1:0] SMAX = $signed({3'b000, {(W-1){1'b1}}});
    localparam logic signed [W+1:0] SMIN = $signed({3'b111, {(W-1){1'b0}}});

    state_t              state;
    logic [AW-1:0]       i;
    logic [AW-1:0]       len;
    logic                fwd;
    logic                eo;
    logic signed [W-1:0] c_q;
    logic signed [W-1:0] a_q;

    logic [AW-1:0]       i_nx;
    logic [AW-1:0]       b_idx;
    logic signed [W-1:0] b_v;
    logic signed [W+1:0] sum;
    logic signed [W+1:0] adj;
    logic signed [W+1:0] c_ext;
    logic signed [W+1:0] res_w;
    logic signed [W-1:0] res;

    assign i_nx  = i + 1'b1;
    // Right neighbour of a predict step clamps at the row end.
    assign b_idx = eo ? ((i == len) ? i : i_nx) : i;

    always_comb begin
        b_v   = eo ? dout_even : dout_odd;
        sum   = $signed({{2{a_q[W-1]}}, a_q}) + $signed({{2{b_v[W-1]}}, b_v});
        adj   = eo ? (sum >>> 1) : ((sum + TWO) >>> 2);
        c_ext = $signed({{2{c_q[W-1]}}, c_q});
        res_w = (fwd == eo) ? (c_ext - adj) : (c_ext + adj);
`ifdef LIFT_SAT_EN
        if (res_w > SMAX)
            res = SMAX[W-1:0];
        else if (res_w < SMIN)
            res = SMIN[W-1:0];
        else
            res = res_w[W-1:0];
`else
        res = res_w[W-1:0];
`endif
    end

`ifndef LIFT_SAT_EN
    logic unused_hi;
    assign unused_hi = ^{res_w[W+1:W], SMAX[0], SMIN[0]};
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            i         <= '0;
            len       <= '0;
            fwd       <= 1'b0;
            eo        <= 1'b0;
            c_q       <= '0;
            a_q       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            addr_even <= '0;
            addr_odd  <= '0;
            we_even   <= 1'b0;
            we_odd    <= 1'b0;
            din_even  <= '0;
            din_odd   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        fwd       <= fwd_inv;
                        eo        <= even_odd;
                        len       <= len_m1;
                        i         <= '0;
                        busy      <= 1'b1;
                        addr_even <= '0;
                        addr_odd  <= '0;
                        state     <= RD0;
                    end
                end
                RD0: begin
                    if (eo)
                        addr_even <= b_idx;
                    else
                        addr_odd <= b_idx;
                    state <= RD1;
                end
                RD1: begin
                    c_q   <= eo ? dout_odd : dout_even;
                    a_q   <= eo ? dout_even : dout_odd;
                    state <= CALC;
                end
                CALC: begin
                    if (eo) begin
                        addr_odd <= i;
                        we_odd   <= 1'b1;
                        din_odd  <= res;
                    end else begin
                        addr_even <= i;
                        we_even   <= 1'b1;
                        din_even  <= res;
                    end
                    state <= WR;
                end
                WR: begin
                    we_even <= 1'b0;
                    we_odd  <= 1'b0;
                    if (i == len) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        i <= i_nx;
                        // Left neighbour of an update step is i_nx-1 = i.
                        if (eo) begin
                            addr_odd  <= i_nx;
                            addr_even <= i_nx;
                        end else begin
                            addr_even <= i_nx;
                            addr_odd  <= i;
                        end
                        state <= RD0;
                    end
                end
                FIN: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_lift_seq.sv
// Self-checking bench for lift_seq: RAM model, random passes, reference model.
// Build with LIFT_SAT_EN defined to check the saturating variant.
module tb_lift_seq;

    localparam int W  = 26;
    localparam int AW = 7;
    localparam int NM = 128;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                start;
    logic                fwd_inv;
    logic                even_odd;
    logic [AW-1:0]       len_m1;
    logic                busy;
    logic                done;
    logic [AW-1:0]       addr_even;
    logic [AW-1:0]       addr_odd;
    logic                we_even;
    logic                we_odd;
    logic signed [W-1:0] din_even;
    logic signed [W-1:0] din_odd;
    logic signed [W-1:0] dout_even;
    logic signed [W-1:0] dout_odd;

    lift_seq #(.W(W), .AW(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .fwd_inv(fwd_inv),
        .even_odd(even_odd), .len_m1(len_m1), .busy(busy), .done(done),
        .addr_even(addr_even), .addr_odd(addr_odd),
        .we_even(we_even), .we_odd(we_odd),
        .din_even(din_even), .din_odd(din_odd),
        .dout_even(dout_even), .dout_odd(dout_odd)
    );

    always #5 clk = ~clk;

    logic signed [W-1:0] mem_e [NM];
    logic signed [W-1:0] mem_o [NM];
    longint              m_e [NM];
    longint              m_o [NM];

    always @(posedge clk) begin
        if (we_even) mem_e[addr_even] <= din_even;
        if (we_odd)  mem_o[addr_odd]  <= din_odd;
        dout_even <= mem_e[addr_even];
        dout_odd  <= mem_o[addr_odd];
    end

    int total = 0;
    int bad = 0;
    int cur_len = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    int mon_err = 0;
    int wr_total = 0;
    bit wlog_bank [4096];
    int wlog_addr [4096];

    always @(negedge clk) begin
        if (busy) busy_cnt++;
        if (done) done_cnt++;
        if (we_even && we_odd) mon_err++;
        if (busy && (int'(addr_even) > cur_len || int'(addr_odd) > cur_len))
            mon_err++;
        if (we_even) begin
            wlog_bank[wr_total % 4096] = 1'b0;
            wlog_addr[wr_total % 4096] = int'(addr_even);
            wr_total++;
        end
        if (we_odd) begin
            wlog_bank[wr_total % 4096] = 1'b1;
            wlog_addr[wr_total % 4096] = int'(addr_odd);
            wr_total++;
        end
    end

    function automatic longint fdiv(input longint x, input longint d);
        longint q;
        q = x / d;
        if ((x % d) != 0 && x < 0) q = q - 1;
        return q;
    endfunction

    function automatic longint fit(input longint v);
        longint lo, hi, span, r;
        hi   = (64'sd1 <<< (W - 1)) - 1;
        lo   = -(64'sd1 <<< (W - 1));
        span = 64'sd1 <<< W;
`ifdef LIFT_SAT_EN
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
`else
        r = ((v - lo) % span + span) % span;
        return r + lo;
`endif
    endfunction

    task automatic model_pass(input bit f, input bit eo, input int len, input int upto);
        longint ne [NM];
        longint no [NM];
        longint a, b, d;
        for (int k = 0; k < NM; k++) begin
            ne[k] = m_e[k];
            no[k] = m_o[k];
        end
        for (int k = 0; k <= upto; k++) begin
            if (eo) begin
                a = m_e[k];
                b = m_e[(k == len) ? k : k + 1];
                d = fdiv(a + b, 2);
                no[k] = fit(f ? m_o[k] - d : m_o[k] + d);
            end else begin
                a = m_o[(k == 0) ? 0 : k - 1];
                b = m_o[k];
                d = fdiv(a + b + 2, 4);
                ne[k] = fit(f ? m_e[k] + d : m_e[k] - d);
            end
        end
        for (int k = 0; k < NM; k++) begin
            m_e[k] = ne[k];
            m_o[k] = no[k];
        end
    endtask

    task automatic load(input int k, input longint e, input longint o);
        mem_e[k] = W'(e);
        mem_o[k] = W'(o);
        m_e[k]   = fit(e);
        m_o[k]   = fit(o);
    endtask

    task automatic compare_mem(input string name);
        for (int k = 0; k < NM; k++) begin
            total += 2;
            if (longint'(mem_e[k]) !== m_e[k]) begin
                bad++;
                $display("FAIL %s even[%0d]: got %0d expected %0d", name, k, mem_e[k], m_e[k]);
            end
            if (longint'(mem_o[k]) !== m_o[k]) begin
                bad++;
                $display("FAIL %s odd[%0d]: got %0d expected %0d", name, k, mem_o[k], m_o[k]);
            end
        end
    endtask

    task automatic run_pass(input string name, input bit f, input bit eo,
                            input int len, input bit extra_start);
        int  b0, d0, w0, e0, n, wc;
        bit  tmo, seq_ok;
        b0 = busy_cnt; d0 = done_cnt; w0 = wr_total; e0 = mon_err;
        @(negedge clk);
        cur_len  = len;
        fwd_inv  = f;
        even_odd = eo;
        len_m1   = AW'(len);
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        fwd_inv  = ~f;
        even_odd = ~eo;
        len_m1   = '0;
        if (extra_start) begin
            repeat (5) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        tmo = 1'b1;
        for (n = 0; n < 700; n++) begin
            @(posedge clk);
            if (done_cnt != d0) begin
                tmo = 1'b0;
                break;
            end
        end
        repeat (30) @(posedge clk);
        wc = wr_total - w0;
        seq_ok = 1'b1;
        for (int k = 0; k < wc; k++)
            if (wlog_bank[(w0 + k) % 4096] != eo || wlog_addr[(w0 + k) % 4096] != k)
                seq_ok = 1'b0;
        model_pass(f, eo, len, len);
        total += 6;
        if (tmo) begin
            bad++;
            $display("FAIL %s timeout: no done within bound", name);
        end
        if (busy_cnt - b0 !== 4 * (len + 1)) begin
            bad++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt - b0, 4 * (len + 1));
        end
        if (done_cnt - d0 !== 1) begin
            bad++;
            $display("FAIL %s done_pulses: got %0d expected 1", name, done_cnt - d0);
        end
        if (wc !== len + 1) begin
            bad++;
            $display("FAIL %s writes: got %0d expected %0d", name, wc, len + 1);
        end
        if (!seq_ok) begin
            bad++;
            $display("FAIL %s write_seq: got bad bank/address order expected bank %0d addr 0..%0d", name, eo, len);
        end
        if (mon_err - e0 !== 0) begin
            bad++;
            $display("FAIL %s protocol: got %0d violations expected 0", name, mon_err - e0);
        end
        compare_mem(name);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; fwd_inv = 1'b0; even_odd = 1'b0; len_m1 = '0;
        repeat (3) @(negedge clk);
        total++;
        if ({busy, done, we_even, we_odd, addr_even, addr_odd, din_even, din_odd} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got busy=%0d done=%0d we=%0d%0d ae=%0d ao=%0d expected all 0",
                     busy, done, we_even, we_odd, addr_even, addr_odd);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL reset_idle: got busy=%0d done=%0d expected 0 0", busy, done);
        end
    endtask

    task automatic test_directed();
        int exp_o [4] = '{0, 0, 0, 5};
        int exp_e [4] = '{10, 20, 30, 41};
        for (int k = 0; k < NM; k++) load(k, 0, 0);
        for (int k = 0; k < 4; k++) load(k, 10 * (k + 1), 10 * (k + 1) + 5);
        run_pass("fwd_predict", 1'b1, 1'b1, 3, 1'b0);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (longint'(mem_o[k]) !== longint'(exp_o[k])) begin
                bad++;
                $display("FAIL fwd_predict_lit[%0d]: got %0d expected %0d", k, mem_o[k], exp_o[k]);
            end
        end
        run_pass("fwd_update", 1'b1, 1'b0, 3, 1'b0);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (longint'(mem_e[k]) !== longint'(exp_e[k])) begin
                bad++;
                $display("FAIL fwd_update_lit[%0d]: got %0d expected %0d", k, mem_e[k], exp_e[k]);
            end
        end
        run_pass("inv_update", 1'b0, 1'b0, 3, 1'b0);
        run_pass("inv_predict", 1'b0, 1'b1, 3, 1'b0);
        for (int k = 0; k < 4; k++) begin
            total += 2;
            if (longint'(mem_e[k]) !== longint'(10 * (k + 1))) begin
                bad++;
                $display("FAIL recon_even[%0d]: got %0d expected %0d", k, mem_e[k], 10 * (k + 1));
            end
            if (longint'(mem_o[k]) !== longint'(10 * (k + 1) + 5)) begin
                bad++;
                $display("FAIL recon_odd[%0d]: got %0d expected %0d", k, mem_o[k], 10 * (k + 1) + 5);
            end
        end
    endtask

    task automatic test_neg_round();
        load(0, -3, 0);
        run_pass("neg_len0", 1'b1, 1'b1, 0, 1'b0);
        total++;
        if (mem_o[0] !== 26'sd3) begin
            bad++;
            $display("FAIL neg_len0_lit: got %0d expected 3", mem_o[0]);
        end
        load(0, -3, 0);
        load(1, 0, 0);
        run_pass("neg_floor", 1'b1, 1'b1, 1, 1'b0);
        total++;
        if (mem_o[0] !== 26'sd2) begin
            bad++;
            $display("FAIL neg_floor_lit: got %0d expected 2", mem_o[0]);
        end
    endtask

    task automatic test_overflow();
        longint expv;
`ifdef LIFT_SAT_EN
        expv = 33554431;
`else
        expv = -1;
`endif
        load(0, -33554432, 33554431);
        load(1, -33554432, 0);
        run_pass("overflow", 1'b1, 1'b1, 1, 1'b0);
        total++;
        if (longint'(mem_o[0]) !== expv) begin
            bad++;
            $display("FAIL overflow_lit: got %0d expected %0d", mem_o[0], expv);
        end
    endtask

    task automatic test_back_to_back();
        int d0;
        for (int k = 0; k < 8; k++) load(k, $signed(W'($urandom)), $signed(W'($urandom)));
        run_pass("start_ignored", 1'b1, 1'b0, 5, 1'b1);
        d0 = done_cnt;
        repeat (20) @(negedge clk);
        total++;
        if (done_cnt !== d0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL start_ignored_idle: got done_delta=%0d busy=%0d expected 0 0", done_cnt - d0, busy);
        end
    endtask

    task automatic test_mid_reset();
        int d0, w0;
        for (int k = 0; k < 4; k++) load(k, $signed(W'($urandom)), $signed(W'($urandom)));
        d0 = done_cnt; w0 = wr_total;
        @(negedge clk);
        cur_len = 3; fwd_inv = 1'b1; even_odd = 1'b1; len_m1 = 7'd3; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        total++;
        if ({busy, done, we_even, we_odd, addr_even, addr_odd, din_even, din_odd} !== '0) begin
            bad++;
            $display("FAIL mid_reset_outputs: got busy=%0d done=%0d we=%0d%0d ae=%0d ao=%0d expected all 0",
                     busy, done, we_even, we_odd, addr_even, addr_odd);
        end
        rst_n = 1'b1;
        repeat (20) @(negedge clk);
        model_pass(1'b1, 1'b1, 3, 1);
        total += 2;
        if (wr_total - w0 !== 2) begin
            bad++;
            $display("FAIL mid_reset_writes: got %0d expected 2", wr_total - w0);
        end
        if (done_cnt - d0 !== 0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_done: got done_delta=%0d busy=%0d expected 0 0", done_cnt - d0, busy);
        end
        compare_mem("mid_reset_mem");
        run_pass("after_reset", 1'b0, 1'b1, 3, 1'b0);
    endtask

    task automatic test_random();
        int len;
        for (int p = 0; p < 20; p++) begin
            for (int k = 0; k < NM; k++)
                load(k, $signed(W'($urandom)), $signed(W'($urandom)));
            len = (p == 0) ? NM - 1 : int'($urandom_range(0, 31));
            run_pass("random", 1'($urandom), 1'($urandom), len, 1'b0);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_neg_round();
        test_overflow();
        test_back_to_back();
        test_mid_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
